// File: rtl/lsu_ctrl.sv
// RV32I load/store controller: decodes memory ops, drives a req/gnt/rvalid data bus,
// aligns store lanes, extends load data and reports misalignment or bus timeout.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        ex_valid,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, accept, misaligned, timed_out, in_req;
  logic [3:0]  wstrb_new;
  logic [31:0] wdata_new, load_ext;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    if (opcode == 7'b0000011) begin
      is_load = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
    end else if (opcode == 7'b0100011) begin
      is_store = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end
  end

  // Gating with rst keeps stall low while reset is held even if the core presents a load.
  assign accept     = rst && ex_valid && (is_load || is_store);
  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign timed_out  = (cnt_q == LAST_CNT);

  always_comb begin
    wstrb_new = 4'b1111;
    wdata_new = store_data;
    case (funct3[1:0])
      2'b00: begin
        wstrb_new = 4'b0001 << addr[1:0];
        wdata_new = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb_new = addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign byte_lane = mem_rdata[{off_q, 3'b000} +: 8];
  assign half_lane = mem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_ext = {24'b0, byte_lane};
      3'b101:  load_ext = {16'b0, half_lane};
      default: load_ext = mem_rdata;
    endcase
  end

  // Result and error registers are only non-zero during the single DONE cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    addr_d     = addr_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    wb_data_d  = '0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          off_d      = addr[1:0];
          addr_d     = {addr[31:2], 2'b00};
          wstrb_d    = wstrb_new;
          wdata_d    = wdata_new;
          cnt_d      = '0;
          if (misaligned) begin
            state_d    = S_DONE;
            misalign_d = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_gnt && is_store_q) begin
          state_d = S_DONE;
        end else if (timed_out) begin
          state_d   = S_DONE;
          bus_err_d = 1'b1;
        end else if (mem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_rvalid) begin
          state_d   = S_DONE;
          wb_data_d = load_ext;
        end else if (timed_out) begin
          state_d   = S_DONE;
          bus_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      off_q      <= '0;
      addr_q     <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      addr_q     <= addr_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign in_req       = (state_q == S_REQ);
  assign stall        = ((state_q == S_IDLE) && accept) || in_req || (state_q == S_WAIT);
  assign mem_req      = in_req;
  assign mem_we       = in_req && is_store_q;
  assign mem_addr     = in_req ? addr_q : '0;
  assign mem_wstrb    = (in_req && is_store_q) ? wstrb_q : '0;
  assign mem_wdata    = (in_req && is_store_q) ? wdata_q : '0;
  assign wb_valid     = (state_q == S_DONE);
  assign wb_data      = wb_data_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a transaction-level model checked every cycle,
// plus directed accesses with hand-computed results.
module tb_lsu_ctrl;

  localparam int TO = 8;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam int P_IDLE = 0, P_BUS = 1, P_DATA = 2, P_DONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0;
  logic        ex_valid = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        stall, wb_valid, misalign_err, bus_err;
  logic [31:0] wb_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .instr(instr), .ex_valid(ex_valid), .addr(addr),
    .store_data(store_data), .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
    .misalign_err(misalign_err), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int vecCount = 0;
  int missCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] mkInstr(input logic [6:0] op, input logic [2:0] f3);
    return {12'h004, 5'd3, f3, 5'd5, op};
  endfunction

  function automatic bit isMemOp(input logic [31:0] ins);
    logic [2:0] f;
    f = ins[14:12];
    if (ins[6:0] == OP_LOAD) return (f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    if (ins[6:0] == OP_STORE) return (f inside {3'b000, 3'b001, 3'b010});
    return 1'b0;
  endfunction

  function automatic int sizeOf(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] strobeOf(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = sizeOf(f3);
    return 4'(((1 << sz) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] laneData(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int sz;
    sz = sizeOf(f3);
    for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] loadValue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int bits;
    bits = 8 * sizeOf(f3);
    v = rd >> (8 * int'(a[1:0]));
    if (bits == 32) return v;
    v = v & ((32'd1 << bits) - 32'd1);
    if (!f3[2] && v[bits-1]) v = v - (32'd1 << bits);
    return v;
  endfunction

  // Reference model: one access at a time, tracked as phase plus cycles spent on the bus.
  int          mPhase = P_IDLE;
  int          mSpent = 0;
  logic        mStore = 1'b0;
  logic [2:0]  mF3 = '0;
  logic [31:0] mAddr = '0, mData = '0, mResult = '0;
  logic        mMis = 1'b0, mBus = 1'b0;

  function automatic bit modelAccepts();
    return rst && ex_valid && (mPhase == P_IDLE) && isMemOp(instr);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mPhase <= P_IDLE; mSpent <= 0; mResult <= '0; mMis <= 1'b0; mBus <= 1'b0;
    end else begin
      mResult <= '0; mMis <= 1'b0; mBus <= 1'b0;
      case (mPhase)
        P_IDLE: if (modelAccepts()) begin
          mStore <= (instr[6:0] == OP_STORE);
          mF3 <= instr[14:12]; mAddr <= addr; mData <= store_data; mSpent <= 0;
          if ((int'(addr[1:0]) % sizeOf(instr[14:12])) != 0) begin
            mPhase <= P_DONE; mMis <= 1'b1;
          end else begin
            mPhase <= P_BUS;
          end
        end
        P_BUS: begin
          mSpent <= mSpent + 1;
          if (mem_gnt && mStore) mPhase <= P_DONE;
          else if (mSpent + 1 == TO) begin mPhase <= P_DONE; mBus <= 1'b1; end
          else if (mem_gnt) mPhase <= P_DATA;
        end
        P_DATA: begin
          mSpent <= mSpent + 1;
          if (mem_rvalid) begin mPhase <= P_DONE; mResult <= loadValue(mF3, mAddr, mem_rdata); end
          else if (mSpent + 1 == TO) begin mPhase <= P_DONE; mBus <= 1'b1; end
        end
        default: mPhase <= P_IDLE;
      endcase
    end
  end

  int          reqCycles = 0, stallCycles = 0, wbCount = 0;
  logic [31:0] lastWbData = '0, lastMemAddr = '0, lastWdata = '0;
  logic [3:0]  lastWstrb = '0;
  logic        lastMis = 1'b0, lastBus = 1'b0, lastWe = 1'b0;

  always @(negedge clk) begin : compare
    logic busy, inBus, wr;
    busy  = (mPhase == P_BUS) || (mPhase == P_DATA);
    inBus = (mPhase == P_BUS);
    wr    = inBus && mStore;
    checkOutput("stall", 32'(stall), 32'(modelAccepts() || busy));
    checkOutput("mem_req", 32'(mem_req), 32'(inBus));
    checkOutput("mem_we", 32'(mem_we), 32'(wr));
    checkOutput("mem_addr", mem_addr, inBus ? {mAddr[31:2], 2'b00} : 32'd0);
    checkOutput("mem_wstrb", 32'(mem_wstrb), wr ? 32'(strobeOf(mF3, mAddr)) : 32'd0);
    checkOutput("mem_wdata", mem_wdata, wr ? laneData(mF3, mData) : 32'd0);
    checkOutput("wb_valid", 32'(wb_valid), 32'(mPhase == P_DONE));
    checkOutput("wb_data", wb_data, (mPhase == P_DONE) ? mResult : 32'd0);
    checkOutput("misalign_err", 32'(misalign_err), 32'((mPhase == P_DONE) && mMis));
    checkOutput("bus_err", 32'(bus_err), 32'((mPhase == P_DONE) && mBus));
    if (mem_req) begin
      reqCycles++; lastMemAddr = mem_addr; lastWstrb = mem_wstrb; lastWdata = mem_wdata; lastWe = mem_we;
    end
    if (stall) stallCycles++;
    if (wb_valid) begin
      wbCount++; lastWbData = wb_data; lastMis = misalign_err; lastBus = bus_err;
    end
  end

  // Cycle 0 is the accept cycle; gnt/rvalid pulse in the cycle indices given (-1 = never).
  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] sd,
                               input int gntCycle, input int rvCycle, input logic [31:0] rd,
                               output int doneIdx);
    bit seen;
    seen = 1'b0;
    doneIdx = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      ex_valid = 1'b1; instr = ins; addr = a; store_data = sd;
      mem_gnt = (i == gntCycle); mem_rvalid = (i == rvCycle); mem_rdata = rd;
      #5;
      if (wb_valid) begin seen = 1'b1; doneIdx = i; end
    end
    if (!seen) checkOutput("access_complete", 32'd0, 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; instr = '0;
  endtask

  task automatic idleCycles(input int n, input logic [31:0] ins, input logic ev);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ex_valid = ev; instr = ins; addr = 32'h0000_1000; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    end
  endtask

  initial begin : stimulus
    int d, s0, r0, w0;
    ex_valid = 1'b1; instr = mkInstr(OP_LOAD, 3'b010);
    #2;
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
    ex_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    applyStimulus(mkInstr(OP_LOAD, 3'b000), 32'h0000_1003, '0, 1, 2, 32'h80AB_CDEF, d);
    checkOutput("lb_latency", 32'(d), 32'd3);
    checkOutput("lb_data", lastWbData, 32'hFFFF_FF80);
    checkOutput("lb_mem_addr", lastMemAddr, 32'h0000_1000);
    applyStimulus(mkInstr(OP_LOAD, 3'b100), 32'h0000_1003, '0, 1, 2, 32'h80AB_CDEF, d);
    checkOutput("lbu_data", lastWbData, 32'h0000_0080);
    applyStimulus(mkInstr(OP_LOAD, 3'b101), 32'h0000_1002, '0, 1, 2, 32'h80AB_CDEF, d);
    checkOutput("lhu_data", lastWbData, 32'h0000_80AB);

    applyStimulus(mkInstr(OP_STORE, 3'b001), 32'h0000_2002, 32'h1234_ABCD, 1, -1, '0, d);
    checkOutput("sh_latency", 32'(d), 32'd2);
    checkOutput("sh_we", 32'(lastWe), 32'd1);
    checkOutput("sh_mem_addr", lastMemAddr, 32'h0000_2000);
    checkOutput("sh_wstrb", 32'(lastWstrb), 32'h0000_000C);
    checkOutput("sh_wdata", lastWdata, 32'hABCD_ABCD);
    checkOutput("sh_wb_data", lastWbData, 32'd0);

    s0 = stallCycles; r0 = reqCycles;
    applyStimulus(mkInstr(OP_LOAD, 3'b010), 32'h0000_3001, '0, -1, -1, '0, d);
    checkOutput("lw_mis_latency", 32'(d), 32'd1);
    checkOutput("lw_mis_flag", 32'(lastMis), 32'd1);
    checkOutput("lw_mis_no_req", 32'(reqCycles - r0), 32'd0);
    checkOutput("lw_mis_stall", 32'(stallCycles - s0), 32'd1);
    applyStimulus(mkInstr(OP_LOAD, 3'b101), 32'h0000_9003, '0, -1, -1, '0, d);
    checkOutput("lhu_mis_flag", 32'(lastMis), 32'd1);

    s0 = stallCycles; r0 = reqCycles;
    applyStimulus(mkInstr(OP_STORE, 3'b000), 32'h0000_4001, 32'h1234_56EF, 4, -1, '0, d);
    checkOutput("sb_latency", 32'(d), 32'd5);
    checkOutput("sb_wstrb", 32'(lastWstrb), 32'h0000_0002);
    checkOutput("sb_wdata", lastWdata, 32'hEFEF_EFEF);
    checkOutput("sb_req_cycles", 32'(reqCycles - r0), 32'd4);
    checkOutput("sb_stall", 32'(stallCycles - s0), 32'd5);

    applyStimulus(mkInstr(OP_LOAD, 3'b001), 32'h0000_7000, '0, 1, 3, 32'h1234_F00D, d);
    checkOutput("lh_latency", 32'(d), 32'd4);
    checkOutput("lh_data", lastWbData, 32'hFFFF_F00D);
    applyStimulus(mkInstr(OP_STORE, 3'b010), 32'h0000_8004, 32'hCAFE_F00D, 2, -1, '0, d);
    checkOutput("sw_wstrb", 32'(lastWstrb), 32'h0000_000F);
    checkOutput("sw_wdata", lastWdata, 32'hCAFE_F00D);

    w0 = wbCount;
    applyStimulus(mkInstr(OP_LOAD, 3'b010), 32'h0000_5000, '0, 1, 9, 32'h5555_5555, d);
    checkOutput("timeout_latency", 32'(d), 32'd9);
    checkOutput("timeout_bus_err", 32'(lastBus), 32'd1);
    checkOutput("timeout_wb_data", lastWbData, 32'd0);
    idleCycles(2, '0, 1'b0);
    checkOutput("timeout_single_wb", 32'(wbCount - w0), 32'd1);

    s0 = stallCycles; w0 = wbCount;
    idleCycles(3, mkInstr(OP_ADDI, 3'b000), 1'b1);
    idleCycles(3, mkInstr(OP_LOAD, 3'b110), 1'b1);
    idleCycles(3, mkInstr(OP_STORE, 3'b100), 1'b1);
    idleCycles(3, mkInstr(OP_LOAD, 3'b010), 1'b0);
    checkOutput("nonmem_stall", 32'(stallCycles - s0), 32'd0);
    checkOutput("nonmem_wb", 32'(wbCount - w0), 32'd0);

    w0 = wbCount;
    @(posedge clk); #1 ex_valid = 1'b1; instr = mkInstr(OP_LOAD, 3'b010); addr = 32'h0000_6000;
    @(posedge clk); #1 mem_gnt = 1'b1;
    @(posedge clk); #1 mem_gnt = 1'b0;
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_wait_stall", 32'(stall), 32'd0);
    checkOutput("rst_wait_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1 rst = 1'b1; ex_valid = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    @(posedge clk); #1 mem_gnt = 1'b0; mem_rvalid = 1'b0;
    checkOutput("rst_no_wb", 32'(wbCount - w0), 32'd0);
    applyStimulus(mkInstr(OP_LOAD, 3'b010), 32'h0000_6004, '0, 2, 3, 32'hDEAD_BEEF, d);
    checkOutput("post_rst_latency", 32'(d), 32'd4);
    checkOutput("post_rst_data", lastWbData, 32'hDEAD_BEEF);
    idleCycles(2, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
